// File: rtl/out_port_sched.sv
// rtl/out_port_sched.sv - round-robin output port scheduler with hold/back-pressure FSM
module out_port_sched #(
    parameter int N_REQ     = 5,
    parameter int DATA_W    = 24,
    parameter int STALL_MAX = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   in_data,
    output logic [N_REQ-1:0]          pop,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      tx_busy,
    output logic [N_REQ-1:0]          grant,
    output logic [19:0]               flit_counter,
    output logic                      stall
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [7:0]       hold_cnt;

    logic             found;
    logic [PTR_W-1:0] win;
    int               idx;

    // First active requester at or after rr_ptr, wrapping past the top channel.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            grant        <= '0;
            pop          <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            flit_counter <= '0;
            hold_cnt     <= '0;
            stall        <= 1'b0;
        end else begin
            pop <= '0;
            case (state)
                IDLE: begin
                    if (found && !tx_busy) begin
                        owner     <= win;
                        grant     <= ONE << win;
                        pop       <= ONE << win;
                        out_data  <= in_data[int'(win)*DATA_W +: DATA_W];
                        out_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!tx_busy) begin
                        out_valid    <= 1'b0;
                        grant        <= '0;
                        rr_ptr       <= (owner == LAST) ? '0 : owner + 1'b1;
                        flit_counter <= flit_counter + 20'd1;
                        state        <= IDLE;
                    end else begin
                        // Saturate so a long stall never wraps the counter back under the threshold.
                        if (hold_cnt != 8'hFF)
                            hold_cnt <= hold_cnt + 8'd1;
                        if ({1'b0, hold_cnt} + 9'd1 == 9'(STALL_MAX))
                            stall <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/out_port_sched.md
OUT_PORT_SCHED -- requirements
Module: out_port_sched

Interface
REQ-001 Parameter N_REQ, default 5, number of requesting input channels (N,E,S,W,Local).
REQ-002 Parameter DATA_W, default 24, flit width (HDR_SZ+PL_SZ+ADDR_SZ).
REQ-003 Parameter STALL_MAX, default 255, HOLD cycles before stall flag; range 1..255.
REQ-004 clk  input  1  router clock.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 req  input  N_REQ  per-channel request: FIFO head targets this output port.
REQ-007 in_data  input  N_REQ*DATA_W  FIFO head flits, channel i at bits [i*DATA_W +: DATA_W].
REQ-008 pop  output  N_REQ  one-cycle pulse to the winning FIFO read port.
REQ-009 out_data  output  DATA_W  flit presented to downstream tx.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 tx_busy  input  1  downstream busy; a transfer occurs on a cycle with out_valid=1 and tx_busy=0.
REQ-012 grant  output  N_REQ  one-hot owner of the port, zero in IDLE.
REQ-013 flit_counter  output  20  flits transferred since reset.
REQ-014 stall  output  1  sticky stall flag.

Function
REQ-015 Two-state FSM with states IDLE and HOLD.
REQ-016 In IDLE, when req!=0 and tx_busy=0, the scheduler shall select a winner w by round-robin, searching from index rr_ptr upward with wrap-around.
REQ-017 On that edge: grant<=onehot(w), out_data<=in_data[w], out_valid<=1, pop<=onehot(w) for exactly one cycle, state<=HOLD.
REQ-018 In IDLE with req=0 or tx_busy=1: no state change, pop=0, out_valid=0.
REQ-019 Latency from request sampled to out_valid=1 shall be 1 cycle.
REQ-020 In HOLD, out_data and grant shall stay constant until the transfer completes.
REQ-021 In HOLD with tx_busy=0 on an edge (transfer): out_valid<=0, grant<=0, rr_ptr<=(w+1) mod N_REQ, flit_counter increments, state<=IDLE.
REQ-022 In HOLD with tx_busy=1: remain in HOLD, increment the hold counter (8 bits).
REQ-023 When the hold counter reaches STALL_MAX, stall shall be set; it stays set until reset.
REQ-024 The hold counter shall clear on every entry to HOLD.
REQ-025 Changes on req or in_data during HOLD shall be ignored.
REQ-026 Peak throughput shall be one flit per 2 cycles.
REQ-027 The FSM shall be back in IDLE before the popped FIFO's updated req is next sampled, so no double-pop can occur.
REQ-028 flit_counter shall wrap from 2^20-1 to 0 without flagging.
REQ-029 A grant for channel w shall never be issued twice without an intervening transfer.
REQ-030 If a single requester is active, it shall win on every arbitration regardless of rr_ptr.
REQ-031 pop shall never have more than one bit set.

Reset
REQ-032 While reset=1 at an edge: state=IDLE, rr_ptr=0, grant=0, pop=0, out_valid=0, out_data=0, flit_counter=0, hold counter=0, stall=0.
REQ-033 Reset asserted mid-HOLD shall abandon the flit without counting it and without a further pop.
REQ-034 After reset, channel 0 shall have highest priority.

Verification
REQ-035 Single request: reset, then req=5'b00100, in_data[2]=24'hABCDEF, tx_busy=0 -> next cycle grant=00100, pop=00100 (1 cycle), out_valid=1, out_data=ABCDEF; following cycle out_valid=0, flit_counter=1.
REQ-036 Round-robin fairness: req=5'b11111 held for 10 flits, tx_busy=0 -> grant order 0,1,2,3,4,0,1,2,3,4; flit_counter=10 after 20 cycles.
REQ-037 Back-pressure: grant channel 1, then tx_busy=1 for 6 cycles -> out_valid and out_data stable for 6 cycles, no second pop; transfer on the 7th cycle.
REQ-038 Stall: STALL_MAX=4, tx_busy=1 after grant -> stall=1 after 4 HOLD cycles; tx_busy=0 -> transfer completes, stall remains 1 until reset.
REQ-039 Reset mid-HOLD: grant channel 3, assert reset during HOLD -> next cycle all outputs zero, flit_counter=0, and the first grant after reset with req=11111 goes to channel 0.
REQ-040 Counter wrap: preload via 2^20 transfers (or force) -> flit_counter reads 0 after transfer 1,048,576.
